// File: rtl/resp_sig_capture_if.sv
// ---------------------------------------------------------------------------
// resp_sig_capture_if
//
// Purpose:
//   Bundles the run-control, serial response and result handshake signals of
//   the response signature capture stage.
//
// Parameters:
//   SIG_W - signature width
//   CNT_W - window length / ones counter width
//
// Signals:
//   start        - request a capture run (master -> slave)
//   win_len      - number of response bits to capture (master -> slave)
//   resp_bit     - serial DUT response bit (master -> slave)
//   result_ack   - consumer acknowledge of a held result (master -> slave)
//   busy         - run in progress (slave -> master)
//   result_valid - signature and ones count are held (slave -> master)
//   sig          - compacted signature (slave -> master)
//   ones_cnt     - number of captured 1 bits (slave -> master)
//
// Optional (RESP_SIG_GOLDEN_CMP_EN defined):
//   golden_sig   - expected signature (master -> slave)
//   golden_ones  - expected ones count (master -> slave)
//   mismatch     - held result differs from golden values (slave -> master)
//
// Modports:
//   master - bench / logger side
//   slave  - capture stage side
// ---------------------------------------------------------------------------
interface resp_sig_capture_if #(
    parameter int SIG_W = 16,
    parameter int CNT_W = 16
);
    logic             start;
    logic [CNT_W-1:0] win_len;
    logic             resp_bit;
    logic             result_ack;
    logic             busy;
    logic             result_valid;
    logic [SIG_W-1:0] sig;
    logic [CNT_W-1:0] ones_cnt;
`ifdef RESP_SIG_GOLDEN_CMP_EN
    logic [SIG_W-1:0] golden_sig;
    logic [CNT_W-1:0] golden_ones;
    logic             mismatch;

    modport master (
        output start, win_len, resp_bit, result_ack, golden_sig, golden_ones,
        input  busy, result_valid, sig, ones_cnt, mismatch
    );

    modport slave (
        input  start, win_len, resp_bit, result_ack, golden_sig, golden_ones,
        output busy, result_valid, sig, ones_cnt, mismatch
    );
`else
    modport master (
        output start, win_len, resp_bit, result_ack,
        input  busy, result_valid, sig, ones_cnt
    );

    modport slave (
        input  start, win_len, resp_bit, result_ack,
        output busy, result_valid, sig, ones_cnt
    );
`endif
endinterface

// File: rtl/resp_sig_capture.sv
// ---------------------------------------------------------------------------
// resp_sig_capture
//
// Purpose:
//   Downstream capture stage for the single-bit benchmark DUT response.
//   Over a programmed window the serial response is compacted into a SISR
//   signature while the number of 1 bits is counted. The result is held
//   behind a valid/ack handshake so a consumer reads one word per run.
//
// Parameters:
//   SIG_W  - signature width (>= 2)
//   CNT_W  - window length and ones counter width
//   POLY   - SISR feedback polynomial
//   SEED   - signature value loaded at every accepted start
//   SETTLE - cycles discarded after start before sampling (0 allowed)
//
// Ports:
//   CK    - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - resp_sig_capture_if.slave (start, win_len, resp_bit, result_ack,
//           busy, result_valid, sig, ones_cnt)
//
// Optional feature:
//   Macro RESP_SIG_GOLDEN_CMP_EN adds golden_sig / golden_ones inputs and a
//   mismatch output on the interface, registered when the result is held.
// ---------------------------------------------------------------------------
module resp_sig_capture #(
    parameter int               SIG_W  = 16,
    parameter int               CNT_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = 16'h1021,
    parameter logic [SIG_W-1:0] SEED   = 16'hFFFF,
    parameter int               SETTLE = 1
) (
    input  logic                  CK,
    input  logic                  reset,
    resp_sig_capture_if.slave     bus
);

    // Settle counter only needs to hold SETTLE-1; keep at least one bit so
    // the SETTLE = 0 build still has a legal declaration.
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SET_W-1:0] SETTLE_LOAD =
        (SETTLE > 0) ? SET_W'(SETTLE - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SKIP = 2'd1,
        CAPT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t           state_q, state_n;
    logic [SIG_W-1:0] sig_q, sig_n;
    logic [CNT_W-1:0] ones_q, ones_n;
    logic [CNT_W-1:0] rem_q, rem_n;
    logic [SET_W-1:0] settle_q, settle_n;
    logic             fb;

    // State and datapath registers; everything returns to zero on reset so a
    // run interrupted by reset leaves no partial signature behind.
    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sig_q    <= '0;
            ones_q   <= '0;
            rem_q    <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_n;
            sig_q    <= sig_n;
            ones_q   <= ones_n;
            rem_q    <= rem_n;
            settle_q <= settle_n;
        end
    end

    // Next-state and datapath logic. The signature and count only move in
    // CAPT, so they stay frozen in HOLD and keep their value in IDLE until
    // the next accepted start reloads them.
    always_comb begin
        state_n  = state_q;
        sig_n    = sig_q;
        ones_n   = ones_q;
        rem_n    = rem_q;
        settle_n = settle_q;
        fb       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sig_n    = SEED;
                    ones_n   = '0;
                    rem_n    = bus.win_len;
                    settle_n = SETTLE_LOAD;
                    // An empty window is complete the moment it is accepted.
                    if (bus.win_len == '0) begin
                        state_n = HOLD;
                    end else if (SETTLE > 0) begin
                        state_n = SKIP;
                    end else begin
                        state_n = CAPT;
                    end
                end
            end

            SKIP: begin
                if (settle_q == '0) begin
                    state_n = CAPT;
                end else begin
                    settle_n = settle_q - SET_W'(1);
                end
            end

            CAPT: begin
                // Serial-input signature: the incoming bit is folded into the
                // feedback tap rather than injected at bit 0.
                fb     = sig_q[SIG_W-1] ^ bus.resp_bit;
                sig_n  = {sig_q[SIG_W-2:0], 1'b0} ^ (fb ? POLY : '0);
                ones_n = ones_q + {{(CNT_W-1){1'b0}}, bus.resp_bit};
                rem_n  = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_n = HOLD;
                end
            end

            HOLD: begin
                // A start arriving with the ack is deliberately dropped.
                if (bus.result_ack) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

`ifdef RESP_SIG_GOLDEN_CMP_EN
    logic mismatch_q, mismatch_n;

    // The comparison uses the values being written on the HOLD-entry edge,
    // so mismatch is ready in the same cycle result_valid rises.
    always_comb begin
        mismatch_n = mismatch_q;
        if (state_q == IDLE && bus.start) begin
            mismatch_n = 1'b0;
        end
        if (state_n == HOLD && state_q != HOLD) begin
            mismatch_n = (sig_n != bus.golden_sig) || (ones_n != bus.golden_ones);
        end
    end

    // Golden-compare flag register.
    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch_n;
        end
    end

    assign bus.mismatch = mismatch_q;
`endif

    assign bus.busy         = (state_q == SKIP) || (state_q == CAPT);
    assign bus.result_valid = (state_q == HOLD);
    assign bus.sig          = sig_q;
    assign bus.ones_cnt     = ones_q;

endmodule

// File: tb/tb_resp_sig_capture.sv
// ---------------------------------------------------------------------------
// tb_resp_sig_capture
//
// Purpose:
//   Self-checking bench for resp_sig_capture. Two instances share the same
//   stimulus: dut0 built with SETTLE = 0 and dut1 with the default SETTLE = 1,
//   so every vector exercises both the direct and the settle-discard paths.
//   Define RESP_SIG_GOLDEN_CMP_EN to also exercise the golden compare.
// ---------------------------------------------------------------------------
module tb_resp_sig_capture;

    logic        CK;
    logic        reset;
    logic        start;
    logic [15:0] win_len;
    logic        resp_bit;
    logic        result_ack;
`ifdef RESP_SIG_GOLDEN_CMP_EN
    logic [15:0] golden_sig;
    logic [15:0] golden_ones;
`endif

    int checks;
    int errors;

    resp_sig_capture_if #(.SIG_W(16), .CNT_W(16)) bus0 ();
    resp_sig_capture_if #(.SIG_W(16), .CNT_W(16)) bus1 ();

    assign bus0.start      = start;
    assign bus0.win_len    = win_len;
    assign bus0.resp_bit   = resp_bit;
    assign bus0.result_ack = result_ack;
    assign bus1.start      = start;
    assign bus1.win_len    = win_len;
    assign bus1.resp_bit   = resp_bit;
    assign bus1.result_ack = result_ack;
`ifdef RESP_SIG_GOLDEN_CMP_EN
    assign bus0.golden_sig  = golden_sig;
    assign bus0.golden_ones = golden_ones;
    assign bus1.golden_sig  = golden_sig;
    assign bus1.golden_ones = golden_ones;
`endif

    resp_sig_capture #(.SETTLE(0)) dut0 (
        .CK    (CK),
        .reset (reset),
        .bus   (bus0)
    );

    resp_sig_capture #(.SETTLE(1)) dut1 (
        .CK    (CK),
        .reset (reset),
        .bus   (bus1)
    );

    // 100 MHz-style free-running clock.
    initial CK = 1'b0;
    always #5 CK = ~CK;

    // One vector: stream bit k is the response presented before edge E(k+1),
    // where E0 is the start edge. Expected values are hand-computed for the
    // SETTLE=0 (sig0/ones0) and SETTLE=1 (sig1/ones1) instances.
    typedef struct packed {
        logic [15:0] win_len;
        logic [7:0]  stream;
        logic [15:0] sig0;
        logic [15:0] ones0;
        logic [15:0] sig1;
        logic [15:0] ones1;
    } vec_t;

    // Compare one value and count it.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Deterministic long response pattern for the reset scenario.
    function automatic logic pat(input int k);
        return ((k % 3) == 0) ^ ((k % 7) == 2);
    endfunction

    // Reference SISR over pat(); returns {signature, ones}.
    function automatic logic [31:0] model(input int settle, input int n);
        logic [15:0] s;
        logic [15:0] ones;
        logic        b;
        s    = 16'hFFFF;
        ones = 16'd0;
        for (int k = 0; k < n; k++) begin
            b = pat(k + settle);
            if (s[15] ^ b) s = (s << 1) ^ 16'h1021;
            else           s = s << 1;
            ones = ones + {15'd0, b};
        end
        return {s, ones};
    endfunction

    // Run one table vector on both instances, check latency, busy length,
    // result and hold-after-ack behaviour.
    task automatic applyStimulus(input vec_t v, input int idx);
        int lat0, lat1, busy0_n, busy1_n;
        int exp0, exp1;
        lat0 = -1; lat1 = -1; busy0_n = 0; busy1_n = 0;
        exp0 = int'(v.win_len);
        exp1 = (v.win_len == 16'd0) ? 0 : int'(v.win_len) + 1;

        @(negedge CK);
        start    = 1'b1;
        win_len  = v.win_len;
        resp_bit = 1'b0;
        @(negedge CK);
        start    = 1'b0;
        win_len  = 16'd9;
        for (int k = 0; k < 8; k++) begin
            if (lat0 < 0 && bus0.result_valid) lat0 = k;
            if (lat1 < 0 && bus1.result_valid) lat1 = k;
            busy0_n += int'(bus0.busy);
            busy1_n += int'(bus1.busy);
            resp_bit = v.stream[k];
            @(negedge CK);
        end
        resp_bit = 1'b0;

        checkOutput($sformatf("v%0d lat0", idx), 32'(lat0), 32'(exp0));
        checkOutput($sformatf("v%0d lat1", idx), 32'(lat1), 32'(exp1));
        checkOutput($sformatf("v%0d busy0", idx), 32'(busy0_n), 32'(exp0));
        checkOutput($sformatf("v%0d busy1", idx), 32'(busy1_n), 32'(exp1));
        checkOutput($sformatf("v%0d sig0", idx), {16'd0, bus0.sig}, {16'd0, v.sig0});
        checkOutput($sformatf("v%0d ones0", idx), {16'd0, bus0.ones_cnt}, {16'd0, v.ones0});
        checkOutput($sformatf("v%0d sig1", idx), {16'd0, bus1.sig}, {16'd0, v.sig1});
        checkOutput($sformatf("v%0d ones1", idx), {16'd0, bus1.ones_cnt}, {16'd0, v.ones1});

        result_ack = 1'b1;
        @(negedge CK);
        result_ack = 1'b0;
        checkOutput($sformatf("v%0d valid0 after ack", idx), {31'd0, bus0.result_valid}, 32'd0);
        checkOutput($sformatf("v%0d valid1 after ack", idx), {31'd0, bus1.result_valid}, 32'd0);
        checkOutput($sformatf("v%0d sig0 kept", idx), {16'd0, bus0.sig}, {16'd0, v.sig0});
    endtask

    vec_t vecs[6];

    initial begin
        logic [31:0] ref0, ref1;
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        start      = 1'b0;
        win_len    = 16'd0;
        resp_bit   = 1'b0;
        result_ack = 1'b0;
`ifdef RESP_SIG_GOLDEN_CMP_EN
        golden_sig  = 16'd0;
        golden_ones = 16'd0;
`endif

        //              win_len stream  sig0      ones0  sig1      ones1
        vecs[0] = '{16'd1, 8'b0000, 16'hEFDF, 16'd0, 16'hEFDF, 16'd0};
        vecs[1] = '{16'd2, 8'b0111, 16'hFFFC, 16'd2, 16'hFFFC, 16'd2};
        vecs[2] = '{16'd1, 8'b0001, 16'hFFFE, 16'd1, 16'hEFDF, 16'd0};
        vecs[3] = '{16'd2, 8'b0010, 16'hDFBE, 16'd1, 16'hEFDD, 16'd1};
        vecs[4] = '{16'd3, 8'b1101, 16'hDFBA, 16'd2, 16'hBF7C, 16'd2};
        vecs[5] = '{16'd0, 8'b0000, 16'hFFFF, 16'd0, 16'hFFFF, 16'd0};

        // Reset state.
        #12;
        checkOutput("reset busy", {31'd0, bus0.busy}, 32'd0);
        checkOutput("reset valid", {31'd0, bus0.result_valid}, 32'd0);
        checkOutput("reset sig", {16'd0, bus0.sig}, 32'd0);
        checkOutput("reset ones", {16'd0, bus1.ones_cnt}, 32'd0);
        @(negedge CK);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Empty window, then start coinciding with ack must be dropped.
        @(negedge CK);
        start   = 1'b1;
        win_len = 16'd0;
        @(negedge CK);
        checkOutput("empty valid on start edge", {31'd0, bus0.result_valid}, 32'd1);
        checkOutput("empty sig", {16'd0, bus0.sig}, 32'h0000FFFF);
        start      = 1'b1;
        win_len    = 16'd1;
        result_ack = 1'b1;
        @(negedge CK);
        result_ack = 1'b0;
        checkOutput("start with ack valid", {31'd0, bus0.result_valid}, 32'd0);
        checkOutput("start with ack busy", {31'd0, bus0.busy}, 32'd0);
        @(negedge CK);
        start = 1'b0;
        checkOutput("start next cycle busy", {31'd0, bus0.busy}, 32'd1);
        repeat (3) @(negedge CK);
        checkOutput("start next cycle valid", {31'd0, bus1.result_valid}, 32'd1);
        result_ack = 1'b1;
        @(negedge CK);
        result_ack = 1'b0;

        // Reset asserted mid-run after 40 captured bits.
        start   = 1'b1;
        win_len = 16'd100;
        @(negedge CK);
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            resp_bit = pat(k);
            @(negedge CK);
        end
        checkOutput("midrun busy", {31'd0, bus0.busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("async reset busy0", {31'd0, bus0.busy}, 32'd0);
        checkOutput("async reset busy1", {31'd0, bus1.busy}, 32'd0);
        checkOutput("async reset valid", {31'd0, bus0.result_valid}, 32'd0);
        checkOutput("async reset sig", {16'd0, bus0.sig}, 32'd0);
        checkOutput("async reset ones", {16'd0, bus0.ones_cnt}, 32'd0);
        @(negedge CK);
        reset    = 1'b0;
        resp_bit = 1'b0;

        // Fresh run compared against the reference model.
        @(negedge CK);
        start   = 1'b1;
        win_len = 16'd100;
        @(negedge CK);
        start = 1'b0;
        for (int k = 0; k < 102; k++) begin
            resp_bit = pat(k);
            @(negedge CK);
        end
        resp_bit = 1'b0;
        ref0 = model(0, 100);
        ref1 = model(1, 100);
        checkOutput("long valid0", {31'd0, bus0.result_valid}, 32'd1);
        checkOutput("long valid1", {31'd0, bus1.result_valid}, 32'd1);
        checkOutput("long sig0", {16'd0, bus0.sig}, {16'd0, ref0[31:16]});
        checkOutput("long ones0", {16'd0, bus0.ones_cnt}, {16'd0, ref0[15:0]});
        checkOutput("long sig1", {16'd0, bus1.sig}, {16'd0, ref1[31:16]});
        checkOutput("long ones1", {16'd0, bus1.ones_cnt}, {16'd0, ref1[15:0]});
        result_ack = 1'b1;
        @(negedge CK);
        result_ack = 1'b0;

`ifdef RESP_SIG_GOLDEN_CMP_EN
        // Golden compare: matching then mismatching golden signature.
        golden_sig  = 16'hFFFC;
        golden_ones = 16'd2;
        applyStimulus(vecs[1], 10);
        checkOutput("golden last mismatch", {31'd0, bus0.mismatch}, 32'd0);
        golden_sig = 16'hFFFD;
        @(negedge CK);
        start    = 1'b1;
        win_len  = 16'd2;
        @(negedge CK);
        start    = 1'b0;
        resp_bit = 1'b1;
        repeat (3) @(negedge CK);
        resp_bit = 1'b0;
        checkOutput("golden match valid", {31'd0, bus1.result_valid}, 32'd1);
        checkOutput("golden mismatch0", {31'd0, bus0.mismatch}, 32'd1);
        checkOutput("golden mismatch1", {31'd0, bus1.mismatch}, 32'd1);
        result_ack = 1'b1;
        @(negedge CK);
        result_ack = 1'b0;
        golden_sig = 16'hFFFC;
        start      = 1'b1;
        win_len    = 16'd2;
        @(negedge CK);
        start = 1'b0;
        checkOutput("mismatch cleared at start", {31'd0, bus0.mismatch}, 32'd0);
        resp_bit = 1'b1;
        repeat (3) @(negedge CK);
        resp_bit = 1'b0;
        checkOutput("golden match mismatch0", {31'd0, bus0.mismatch}, 32'd0);
        result_ack = 1'b1;
        @(negedge CK);
        result_ack = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
